alu_exec: RTL and testbench
===========================

ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 SHALL provide parameter WIDTH, default 16, the data-path width in bits for all operands and results.
REQ-002 SHALL provide port clk  input  1  rising-edge clock.
REQ-003 SHALL provide port reset  input  1  reset, asynchronous, active-low.
REQ-004 SHALL provide port start  input  1  request strobe, sampled only in IDLE.
REQ-005 SHALL provide port operation  input  4  code from ALU control: 0000 nop, 0001 add, 0010 sub, 0011 mult, 0100 div, 0101 move, 0110 swap, 0111 and, 1000 or, 1001 compare; 1010-1111 illegal.
REQ-006 SHALL provide port a  input  WIDTH  operand A.
REQ-007 SHALL provide port b  input  WIDTH  operand B.
REQ-008 SHALL provide port result  output  WIDTH  primary result.
REQ-009 SHALL provide port result_hi  output  WIDTH  secondary result: mult high half, div remainder, swap A.
REQ-010 SHALL provide port flags  output  4  {carry, zero, lt, eq}.
REQ-011 SHALL provide port busy  output  1  iterative op in progress.
REQ-012 SHALL provide port done  output  1  one-cycle completion pulse.
REQ-013 SHALL provide port err  output  1  sticky until next accepted start: illegal op or divide by zero.

Function
REQ-014 SHALL use states IDLE, MUL, DIV; busy=1 exactly in MUL and DIV.
REQ-015 SHALL accept a request on a rising edge where state=IDLE and start=1; SHALL latch operation, a and b at that edge; SHALL ignore start in any other state.
REQ-016 SHALL complete single-cycle ops (nop, add, sub, move, swap, and, or, compare, illegal) at the accepting edge; result, result_hi, flags, err and done SHALL be valid in the following cycle (latency 1).
REQ-017 Add: result = (a+b) mod 2^WIDTH; carry = bit WIDTH of the sum; result_hi unchanged.
REQ-018 Sub: result = (a-b) mod 2^WIDTH; carry = 1 when a<b (borrow), unsigned.
REQ-019 Move: result=b. Swap: result=b, result_hi=a. And/or: bitwise a&b, a|b. Carry=0 for all four.
REQ-020 Compare: result and result_hi unchanged; eq=(a==b); lt=(a<b) unsigned; carry=0.
REQ-021 Zero flag SHALL equal (result==0) after every completed op except compare and nop, where zero=eq and zero is unchanged respectively.
REQ-022 Nop: done pulses; result, result_hi and flags unchanged; err cleared.
REQ-023 Illegal code: done pulses; result, result_hi and flags unchanged; err=1.
REQ-024 Mult: unsigned shift-add, one bit per cycle; SHALL enter MUL at the accepting edge, remain WIDTH cycles, return to IDLE; {result_hi,result} = a*b (2*WIDTH bits) and done=1 in the cycle after the last iteration (latency WIDTH+1); carry = (result_hi!=0).
REQ-025 Div: unsigned restoring, one quotient bit per cycle, same timing as mult; result=quotient, result_hi=remainder; carry=0.
REQ-026 Div with b==0: SHALL not enter DIV; latency 1; result = all ones, result_hi = a, err=1.
REQ-027 result, result_hi and flags SHALL not change in the cycles between acceptance and completion; internal working registers are separate.
REQ-028 done SHALL be high for exactly one cycle per accepted request; no other done pulses.
REQ-029 Back-to-back: a start in the cycle where done=1 SHALL be accepted (state is IDLE).
REQ-030 err SHALL be cleared at every accepted start whose op does not set it.

Reset
REQ-031 reset low SHALL asynchronously force state=IDLE, result=0, result_hi=0, flags=0000, busy=0, done=0, err=0, and clear working registers.
REQ-032 reset asserted mid MUL/DIV SHALL abort the op with no done pulse; after release the block SHALL accept a new start on the first rising edge.

Verification
REQ-033 WIDTH=16, add a=0xFFFF b=0x0001 -> next cycle result=0x0000, carry=1, zero=1, done one cycle.
REQ-034 mult a=0x1234 b=0x0100 -> busy 16 cycles, done at cycle 17, result_hi=0x0012, result=0x3400, carry=1.
REQ-035 div a=100 b=7 -> done at cycle 17, result=14, result_hi=2, err=0; then div a=5 b=0 -> done next cycle, result=0xFFFF, result_hi=5, err=1.
REQ-036 compare a=3 b=9 -> lt=1, eq=0, zero=0, result unchanged; swap a=0xAAAA b=0x5555 -> result=0x5555, result_hi=0xAAAA.
REQ-037 start mult, pulse start with add during busy -> add ignored, single done; assert reset at cycle 8 -> all outputs 0, no done; new add accepted on first edge after release.
REQ-038 operation=1100 -> done pulse, err=1, result unchanged; following add clears err.

Source files
------------

// File: rtl/alu_exec.sv
// alu_exec: multi-function ALU execute stage.
// Single-cycle ops finish at the accepting edge and are visible one cycle later.
// Multiply and divide iterate one bit per cycle in private working registers, so
// the visible result, result_hi and flags stay stable until those ops complete.
// flags = {carry, zero, lt, eq}. lt and eq are only written by compare and keep
// their previous values across every other op.
module alu_exec #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       operation,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic [3:0]       flags,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_MULT = 4'b0011;
    localparam logic [3:0] OP_DIV  = 4'b0100;
    localparam logic [3:0] OP_MOVE = 4'b0101;
    localparam logic [3:0] OP_SWAP = 4'b0110;
    localparam logic [3:0] OP_AND  = 4'b0111;
    localparam logic [3:0] OP_OR   = 4'b1000;
    localparam logic [3:0] OP_CMP  = 4'b1001;

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] result_hi_q, result_hi_d;
    logic [3:0]       flags_q, flags_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] work_hi_q, work_hi_d;
    logic [WIDTH-1:0] work_lo_q, work_lo_d;
    logic [WIDTH-1:0] operand_q, operand_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   sub_diff;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_next;
    logic [WIDTH-1:0] mul_lo_next;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_trial;
    logic             div_ok;
    logic [WIDTH-1:0] div_rem_next;
    logic [WIDTH-1:0] div_quo_next;

    // Arithmetic datapath: single-cycle add/sub plus one step of each iterative algorithm
    always_comb begin
        add_sum      = {1'b0, a} + {1'b0, b};
        sub_diff     = {1'b0, a} - {1'b0, b};
        mul_sum      = {1'b0, work_hi_q} + {1'b0, (work_lo_q[0] ? operand_q : {WIDTH{1'b0}})};
        mul_hi_next  = mul_sum[WIDTH:1];
        mul_lo_next  = {mul_sum[0], work_lo_q[WIDTH-1:1]};
        div_shift    = {work_hi_q, work_lo_q[WIDTH-1]};
        div_trial    = div_shift - {1'b0, operand_q};
        div_ok       = ~div_trial[WIDTH];
        div_rem_next = div_ok ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
        div_quo_next = {work_lo_q[WIDTH-2:0], div_ok};
    end

    // Next-state and next-output logic for the IDLE/MUL/DIV sequencer
    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        flags_d     = flags_q;
        done_d      = 1'b0;
        err_d       = err_q;
        work_hi_d   = work_hi_q;
        work_lo_d   = work_lo_q;
        operand_d   = operand_q;
        cnt_d       = cnt_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    err_d  = 1'b0;
                    done_d = 1'b1;
                    case (operation)
                        OP_NOP: begin
                        end
                        OP_ADD: begin
                            result_d = add_sum[WIDTH-1:0];
                            flags_d  = {add_sum[WIDTH], (add_sum[WIDTH-1:0] == '0), flags_q[1:0]};
                        end
                        OP_SUB: begin
                            result_d = sub_diff[WIDTH-1:0];
                            flags_d  = {sub_diff[WIDTH], (sub_diff[WIDTH-1:0] == '0), flags_q[1:0]};
                        end
                        OP_MULT: begin
                            state_d   = MUL;
                            done_d    = 1'b0;
                            work_hi_d = '0;
                            work_lo_d = b;
                            operand_d = a;
                            cnt_d     = '0;
                        end
                        OP_DIV: begin
                            if (b == '0) begin
                                result_d    = '1;
                                result_hi_d = a;
                                flags_d     = {1'b0, 1'b0, flags_q[1:0]};
                                err_d       = 1'b1;
                            end else begin
                                state_d   = DIV;
                                done_d    = 1'b0;
                                work_hi_d = '0;
                                work_lo_d = a;
                                operand_d = b;
                                cnt_d     = '0;
                            end
                        end
                        OP_MOVE: begin
                            result_d = b;
                            flags_d  = {1'b0, (b == '0), flags_q[1:0]};
                        end
                        OP_SWAP: begin
                            result_d    = b;
                            result_hi_d = a;
                            flags_d     = {1'b0, (b == '0), flags_q[1:0]};
                        end
                        OP_AND: begin
                            result_d = a & b;
                            flags_d  = {1'b0, ((a & b) == '0), flags_q[1:0]};
                        end
                        OP_OR: begin
                            result_d = a | b;
                            flags_d  = {1'b0, ((a | b) == '0), flags_q[1:0]};
                        end
                        OP_CMP: begin
                            flags_d = {1'b0, (a == b), (a < b), (a == b)};
                        end
                        default: begin
                            err_d = 1'b1;
                        end
                    endcase
                end
            end
            MUL: begin
                work_hi_d = mul_hi_next;
                work_lo_d = mul_lo_next;
                cnt_d     = cnt_q + CW'(1);
                if (cnt_q == LAST_ITER) begin
                    state_d     = IDLE;
                    result_d    = mul_lo_next;
                    result_hi_d = mul_hi_next;
                    flags_d     = {(mul_hi_next != '0), (mul_lo_next == '0), flags_q[1:0]};
                    done_d      = 1'b1;
                end
            end
            DIV: begin
                work_hi_d = div_rem_next;
                work_lo_d = div_quo_next;
                cnt_d     = cnt_q + CW'(1);
                if (cnt_q == LAST_ITER) begin
                    state_d     = IDLE;
                    result_d    = div_quo_next;
                    result_hi_d = div_rem_next;
                    flags_d     = {1'b0, (div_quo_next == '0), flags_q[1:0]};
                    done_d      = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any op in flight without a done pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            result_q    <= '0;
            result_hi_q <= '0;
            flags_q     <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            work_hi_q   <= '0;
            work_lo_q   <= '0;
            operand_q   <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            flags_q     <= flags_d;
            done_q      <= done_d;
            err_q       <= err_d;
            work_hi_q   <= work_hi_d;
            work_lo_q   <= work_lo_d;
            operand_q   <= operand_d;
            cnt_q       <= cnt_d;
        end
    end

    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign flags     = flags_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: scoreboard bench for alu_exec. Stimulus pushes the expected
// completion (computed by a plain-arithmetic model) into a queue; a monitor
// pops and compares whenever done is seen, including the completion cycle.
module tb_alu_exec;

    localparam int W = 16;

    localparam logic [3:0] NOP  = 4'd0;
    localparam logic [3:0] ADD  = 4'd1;
    localparam logic [3:0] SUB  = 4'd2;
    localparam logic [3:0] MULT = 4'd3;
    localparam logic [3:0] DIVO = 4'd4;
    localparam logic [3:0] MOVE = 4'd5;
    localparam logic [3:0] SWAP = 4'd6;
    localparam logic [3:0] ANDO = 4'd7;
    localparam logic [3:0] ORO  = 4'd8;
    localparam logic [3:0] CMP  = 4'd9;

    typedef struct {
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic [3:0]   flg;
        logic         er;
        int           due;
    } exp_t;

    logic         clk;
    logic         reset;
    logic         start;
    logic [3:0]   operation;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] result;
    logic [W-1:0] result_hi;
    logic [3:0]   flags;
    logic         busy;
    logic         done;
    logic         err;

    int errors;
    int checks;
    int cyc;

    exp_t sb[$];
    exp_t mon_e;
    logic [W-1:0] held_res;
    logic [W-1:0] held_hi;
    logic [3:0]   held_flg;

    // Reference model architectural state
    logic [W-1:0] m_res;
    logic [W-1:0] m_hi;
    logic         m_carry;
    logic         m_zero;
    logic         m_lt;
    logic         m_eq;
    logic         m_err;

    alu_exec #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .operation (operation),
        .a         (a),
        .b         (b),
        .result    (result),
        .result_hi (result_hi),
        .flags     (flags),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running cycle count used to check completion latency
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic modelReset();
        m_res = '0; m_hi = '0; m_carry = 0; m_zero = 0; m_lt = 0; m_eq = 0; m_err = 0;
    endtask

    // Behavioural reference: what the architectural state becomes once op completes
    task automatic modelStep(input logic [3:0] op, input logic [W-1:0] av, input logic [W-1:0] bv,
                             output exp_t e);
        longint unsigned s;
        longint unsigned p;
        m_err = 0;
        case (op)
            NOP: ;
            ADD: begin
                s = longint'(av) + longint'(bv);
                m_res = s[W-1:0]; m_carry = s[W]; m_zero = (m_res == 0);
            end
            SUB: begin
                m_res = av - bv; m_carry = (av < bv); m_zero = (m_res == 0);
            end
            MULT: begin
                p = longint'(av) * longint'(bv);
                m_res = p[W-1:0]; m_hi = p[2*W-1:W];
                m_carry = (m_hi != 0); m_zero = (m_res == 0);
            end
            DIVO: begin
                if (bv == 0) begin
                    m_res = '1; m_hi = av; m_carry = 0; m_zero = 0; m_err = 1;
                end else begin
                    m_res = av / bv; m_hi = av % bv; m_carry = 0; m_zero = (m_res == 0);
                end
            end
            MOVE: begin m_res = bv; m_carry = 0; m_zero = (m_res == 0); end
            SWAP: begin m_res = bv; m_hi = av; m_carry = 0; m_zero = (m_res == 0); end
            ANDO: begin m_res = av & bv; m_carry = 0; m_zero = (m_res == 0); end
            ORO:  begin m_res = av | bv; m_carry = 0; m_zero = (m_res == 0); end
            CMP: begin
                m_eq = (av == bv); m_lt = (av < bv); m_carry = 0; m_zero = m_eq;
            end
            default: m_err = 1;
        endcase
        e.res = m_res;
        e.hi  = m_hi;
        e.flg = {m_carry, m_zero, m_lt, m_eq};
        e.er  = m_err;
        e.due = 0;
    endtask

    // Issue one request at the current negedge. mode 0: normal; 1: pulse an add
    // while busy; 2: assert reset in busy cycle 8 and abort.
    task automatic applyStimulus(input logic [3:0] op, input logic [W-1:0] av,
                                 input logic [W-1:0] bv, input int mode);
        exp_t e;
        int   acc;
        bit   iter;
        acc  = cyc;
        iter = (op == MULT) || (op == DIVO && bv != 0);
        operation = op; a = av; b = bv; start = 1'b1;
        if (mode != 2) begin
            modelStep(op, av, bv, e);
            e.due = acc + (iter ? W + 1 : 1);
        end
        @(posedge clk);
        if (mode != 2) sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        operation = 4'($urandom); a = W'($urandom); b = W'($urandom);
        if (iter) begin
            for (int k = 1; k <= W; k++) begin
                checkOutput("busy_high", 32'(busy), 32'd1);
                if (mode == 1 && k == 3) begin start = 1'b1; operation = ADD; end
                if (mode == 1 && k == 4) start = 1'b0;
                if (mode == 2 && k == 8) begin
                    reset = 1'b0;
                    #1;
                    checkOutput("rst_result", 32'(result), 32'd0);
                    checkOutput("rst_result_hi", 32'(result_hi), 32'd0);
                    checkOutput("rst_flags", 32'(flags), 32'd0);
                    checkOutput("rst_busy", 32'(busy), 32'd0);
                    checkOutput("rst_done", 32'(done), 32'd0);
                    checkOutput("rst_err", 32'(err), 32'd0);
                    modelReset();
                    @(negedge clk);
                    @(negedge clk);
                    reset = 1'b1;
                    return;
                end
                @(negedge clk);
            end
            checkOutput("busy_low_at_done", 32'(busy), 32'd0);
        end
    endtask

    // Monitor: compare every done against the oldest expectation; hold outputs while busy
    always @(negedge clk) begin
        if (!reset) begin
            sb.delete();
            held_res = '0; held_hi = '0; held_flg = '0;
        end else if (done) begin
            if (sb.size() == 0) begin
                checkOutput("spurious_done", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                checkOutput("result", 32'(result), 32'(mon_e.res));
                checkOutput("result_hi", 32'(result_hi), 32'(mon_e.hi));
                checkOutput("flags", 32'(flags), 32'(mon_e.flg));
                checkOutput("err", 32'(err), 32'(mon_e.er));
                checkOutput("done_cycle", 32'(cyc), 32'(mon_e.due));
                held_res = mon_e.res; held_hi = mon_e.hi; held_flg = mon_e.flg;
            end
        end else if (busy) begin
            checkOutput("hold_outputs", {result, result_hi}, {held_res, held_hi});
            checkOutput("hold_flags", 32'(flags), 32'(held_flg));
        end
    end

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        int sel;
        errors = 0; checks = 0; cyc = 0;
        reset = 1'b0; start = 1'b0; operation = '0; a = '0; b = '0;
        modelReset();
        repeat (2) @(negedge clk);
        checkOutput("reset_result", 32'(result), 32'd0);
        checkOutput("reset_result_hi", 32'(result_hi), 32'd0);
        checkOutput("reset_flags", 32'(flags), 32'd0);
        checkOutput("reset_ctrl", {29'd0, busy, done, err}, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        applyStimulus(ADD, 16'hFFFF, 16'h0001, 0);
        applyStimulus(MULT, 16'h1234, 16'h0100, 0);
        applyStimulus(DIVO, 16'd100, 16'd7, 0);
        applyStimulus(DIVO, 16'd5, 16'd0, 0);
        applyStimulus(CMP, 16'd3, 16'd9, 0);
        applyStimulus(SWAP, 16'hAAAA, 16'h5555, 0);
        applyStimulus(SUB, 16'd3, 16'd9, 0);
        applyStimulus(4'b1100, 16'h1111, 16'h2222, 0);
        applyStimulus(ADD, 16'h0010, 16'h0020, 0);
        applyStimulus(NOP, 16'h0000, 16'h0000, 0);
        applyStimulus(MULT, 16'hFFFF, 16'hFFFF, 1);
        applyStimulus(MULT, 16'h00FF, 16'h0003, 2);
        applyStimulus(ADD, 16'h0007, 16'h0008, 0);
        applyStimulus(CMP, 16'h4444, 16'h4444, 0);

        for (int i = 0; i < 80; i++) begin
            ra  = W'($urandom);
            sel = $urandom_range(0, 7);
            rb  = (sel == 0) ? '0 : (sel == 1) ? ra : W'($urandom);
            applyStimulus(4'($urandom_range(0, 15)), ra, rb, 0);
        end

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
